// File: rtl/prog_counter_ras.sv
// Program counter with absolute/relative branches, stall, halt state and a
// circular hardware return-address stack (RAS) for call/return.
// The RAS overwrites its oldest entry when a call arrives while it is full.
module prog_counter_ras #(
    parameter int WIDTH     = 9,
    parameter int OFF_W     = 6,
    parameter int RAS_DEPTH = 4,
    localparam int CNT_W    = $clog2(RAS_DEPTH + 1),
    localparam int PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             start,
    input  logic [WIDTH-1:0] start_addr,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch,
    input  logic             taken,
    input  logic             rel,
    input  logic [WIDTH-1:0] target,
    input  logic [OFF_W-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic             halted,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_ovf,
    output logic             ras_unf
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [WIDTH-1:0]   ras_q [RAS_DEPTH];

    logic               push_en_s;
    logic [WIDTH-1:0]   pc_inc_s;
    logic [WIDTH-1:0]   off_ext_s;
    logic [PTR_W-1:0]   ptr_inc_s;
    logic [PTR_W-1:0]   ptr_dec_s;
    logic               ras_full_s;
    logic               ras_empty_s;

    // Datapath helpers: increment, sign-extended offset, circular pointer steps.
    always_comb begin
        pc_inc_s    = pc_q + WIDTH'(1);
        off_ext_s   = WIDTH'($signed(offset));
        ras_full_s  = (cnt_q == CNT_W'(RAS_DEPTH));
        ras_empty_s = (cnt_q == CNT_W'(0));
        if (ptr_q == PTR_W'(RAS_DEPTH - 1)) begin
            ptr_inc_s = PTR_W'(0);
        end else begin
            ptr_inc_s = ptr_q + PTR_W'(1);
        end
        if (ptr_q == PTR_W'(0)) begin
            ptr_dec_s = PTR_W'(RAS_DEPTH - 1);
        end else begin
            ptr_dec_s = ptr_q - PTR_W'(1);
        end
    end

    // Next-state logic: halt > stall > ret > call > taken branch > increment.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    // PC holds; any concurrent branch/call/ret is dropped.
                    state_d = ST_HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (ret) begin
                    if (!ras_empty_s) begin
                        pc_d  = ras_q[ptr_dec_s];
                        ptr_d = ptr_dec_s;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d  = pc_inc_s;
                        unf_d = 1'b1;
                    end
                end else if (call) begin
                    push_en_s = 1'b1;
                    pc_d      = target;
                    ptr_d     = ptr_inc_s;
                    if (ras_full_s) begin
                        // Oldest entry is overwritten; depth stays saturated.
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (branch && taken) begin
                    if (rel) begin
                        pc_d = pc_q + off_ext_s;
                    end else begin
                        pc_d = target;
                    end
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Control state registers; start reloads the PC and clears everything else.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= ST_RUN;
            pc_q    <= start_addr;
            cnt_q   <= CNT_W'(0);
            ptr_q   <= PTR_W'(0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAS storage; contents are don't-care after start, so no reset is applied.
    always_ff @(posedge clk) begin
        if (!start && push_en_s) begin
            ras_q[ptr_q] <= pc_inc_s;
        end else begin
            ras_q[ptr_q] <= ras_q[ptr_q];
        end
    end

    assign pc_out    = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: doc/prog_counter_ras.md
Name: prog_counter_ras

Overview:
Next-generation program counter for the emulator core: a width-parametrised PC with absolute and PC-relative branches, pipeline stall, a halt state, and a hardware return-address stack (RAS) for call/return. It sits at the head of the fetch path and drives the instruction-memory address. The decode/branch unit drives its control inputs.

Parameters:
WIDTH, 9, PC and address width in bits.
OFF_W, 6, width of the signed relative-branch offset (two's complement).
RAS_DEPTH, 4, number of return-address stack entries (>=1).

Ports:
clk  input  1  clock; all state updates on rising edge.
start  input  1  synchronous active-high reset; loads start_addr and clears all state.
start_addr  input  WIDTH  PC value loaded by start.
stall  input  1  hold PC and RAS this cycle.
halt_req  input  1  enter HALT state.
branch  input  1  branch instruction present.
taken  input  1  branch condition true (qualified by branch).
rel  input  1  1 = relative branch (pc+offset), 0 = absolute (target).
target  input  WIDTH  absolute branch/call destination.
offset  input  OFF_W  signed relative offset.
call  input  1  push pc+1, jump to target.
ret  input  1  pop return address into PC.
pc_out  output  WIDTH  current PC (registered).
halted  output  1  1 while in HALT state.
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
ras_ovf  output  1  sticky: a call occurred while RAS full.
ras_unf  output  1  sticky: a ret occurred while RAS empty.

Behaviour:
- Reset is synchronous and active-high on start; clock is clk. start=1 at a rising edge: pc_out=start_addr, halted=0, ras_count=0, ras_ovf=0, ras_unf=0, state=RUN. start overrides every other input. Outputs are undefined before the first start.
- Every output is registered. A control input sampled at edge N takes effect in pc_out after edge N.
- FSM has two states: RUN and HALT. RUN->HALT when halt_req=1 and start=0. HALT->RUN only on start. In HALT: pc_out, RAS and flags hold, all other inputs are ignored, and halted=1.
- Priority in RUN, highest first: halt_req > stall > ret > call > (branch & taken) > increment.
- halt_req: PC holds (not incremented). halted=1 from the next cycle. A concurrent branch, call or ret is discarded.
- stall: PC, RAS and flags all hold.
- ret with ras_count>0: pc <= top entry; ras_count-1.
- ret with ras_count=0: pc <= pc+1; ras_unf <= 1.
- call: push pc+1 (mod 2^WIDTH); pc <= target. If ras_count=RAS_DEPTH, the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_ovf <= 1.
- call and ret together: ret wins; call is ignored.
- branch & taken & !rel: pc <= target.
- branch & taken & rel: pc <= pc + sign_extend(offset, WIDTH), mod 2^WIDTH.
- branch=1, taken=0: pc <= pc+1. taken=1 with branch=0 is ignored.
- Increment wraps: all-ones -> 0. No carry-out flag.
- Sticky flags clear only on start.
- start during a stall, halt or pending call: reset behaviour applies fully, and RAS contents become don't-care (count=0).

Test Plan:
1. start=1, start_addr=0x010; then 3 idle cycles -> pc_out 0x010, 0x011, 0x012, 0x013; halted=0, ras_count=0.
2. pc=0x020; branch=taken=1, rel=1, offset=6'b111100 -> pc 0x01C. Next cycle rel=0, target=0x1F0 -> 0x1F0. branch=1, taken=0 -> 0x1F1.
3. pc=0x1FF idle -> pc 0x000 (wrap). rel branch offset=+5 from 0x1FE -> 0x003.
4. pc=0x040; call target=0x100 -> pc 0x100, ras_count=1. Nested call at 0x100 to 0x150 -> ras_count=2. ret -> 0x101. ret -> 0x041, ras_count=0. Extra ret -> 0x042, ras_unf=1.
5. Five consecutive calls with RAS_DEPTH=4 -> ras_count stays 4, ras_ovf=1. Four rets return the 4 newest return addresses in LIFO order.
6. stall=1 with branch taken -> pc unchanged. halt_req with call -> pc holds, halted=1 next cycle, ras_count unchanged. Inputs ignored for 5 cycles. start=1 -> pc=start_addr, halted=0, flags 0.
